// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential 64/32 restoring divider.
package div_pkg;
  localparam int N_BITS = 32;
  localparam int CNT_W  = 5;

  typedef logic [N_BITS-1:0]   word_t;
  typedef logic [2*N_BITS-1:0] dword_t;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift one dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   i_r,
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_r,
  output logic [W-1:0] o_q
);
  logic [W:0] w_t;
  logic       w_ge;
  logic       w_unused_r_msb;

  // The incoming remainder is always below the divisor, so its top bit is zero.
  assign w_unused_r_msb = i_r[W];

  // The shifted value needs W+1 bits; a W-bit compare would miss T >= 2^W.
  assign w_t  = {i_r[W-1:0], i_q[W-1]};
  assign w_ge = (w_t >= {1'b0, i_divisor});
  assign o_r  = w_ge ? (w_t - {1'b0, i_divisor}) : w_t;
  assign o_q  = {i_q[W-2:0], w_ge};
endmodule

// File: rtl/div64x32_seq.sv
// Sequential unsigned 64/32 divider, one quotient bit per clock, with early
// divide-by-zero and quotient-overflow detection.
module div64x32_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2*N_BITS-1:0]   dividend,
  input  logic [N_BITS-1:0]     divisor,
  output logic                  busy,
  output logic                  done,
  output logic [N_BITS-1:0]     quotient,
  output logic [N_BITS-1:0]     remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);
  div_state_t       r_state;
  div_state_t       w_state_next;
  dword_t           r_dividend;
  word_t            r_divisor;
  logic [N_BITS:0]  r_r;
  word_t            r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  word_t            r_quot;
  word_t            r_rem;
  logic             r_dbz;
  logic             r_ovf;

  logic [N_BITS:0]  w_r_next;
  word_t            w_q_next;
  logic             w_zero;
  logic             w_ovf;

  assign w_zero = (r_divisor == '0);
  assign w_ovf  = (r_dividend[2*N_BITS-1:N_BITS] >= r_divisor);

  div_step #(.W(N_BITS)) u_step (
    .i_r       (r_r),
    .i_q       (r_q),
    .i_divisor (r_divisor),
    .o_r       (w_r_next),
    .o_q       (w_q_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:    if (start) w_state_next = CHECK;
      CHECK:   w_state_next = (w_zero || w_ovf) ? FIN : RUN;
      RUN:     if (r_cnt == '0) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_r        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
          end
        end
        CHECK: begin
          if (w_zero) begin
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
            r_quot <= '1;
            r_rem  <= r_dividend[N_BITS-1:0];
          end else if (w_ovf) begin
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b1;
            r_quot <= '1;
            r_rem  <= r_dividend[N_BITS-1:0];
          end else begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            r_r   <= {1'b0, r_dividend[2*N_BITS-1:N_BITS]};
            r_q   <= r_dividend[N_BITS-1:0];
            r_cnt <= CNT_W'(N_BITS - 1);
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIN: begin
          r_done <= 1'b1;
          // Error results were already published when the check fired.
          if (!r_dbz && !r_ovf) begin
            r_quot <= r_q;
            r_rem  <= r_r[N_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_div64x32_seq.sv
// Self-checking bench for div64x32_seq: vector table, hand-written corner
// sequences and random operands, all checked through a scoreboard queue.
module tb_div64x32_seq;
  import div_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  dword_t dividend = '0;
  word_t  divisor = '0;
  logic   busy, done, div_by_zero, overflow;
  word_t  quotient, remainder;

  div64x32_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    dword_t dd;
    word_t  dv;
    word_t  q;
    word_t  r;
    logic   dbz;
    logic   ovf;
    int     lat;
    bit     post;
  } exp_t;

  exp_t sb[$];
  exp_t vec[10];
  int   n_checks = 0;
  int   n_errors = 0;
  int   g_cyc;
  int   g_busy;

  function automatic exp_t mk(input dword_t dd, input word_t dv, input word_t q,
                              input word_t r, input logic dbz, input logic ovf,
                              input int lat);
    exp_t e;
    e.dd = dd; e.dv = dv; e.q = q; e.r = r;
    e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.post = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    g_cyc++;
    if (busy) g_busy++;
  endtask

  task automatic issue(input exp_t e);
    @(negedge clk);
    start    = 1'b1;
    dividend = e.dd;
    divisor  = e.dv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    g_cyc  = 0;
    g_busy = busy ? 1 : 0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    exp_t e;
    while (!done && g_cyc < 100) tick();
    chk({nm, "_done_seen"}, 64'(done), 64'd1);
    if (sb.size() == 0) begin
      chk({nm, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      if (done) begin
        chk({nm, "_latency"}, 64'(g_cyc), 64'(e.lat));
        chk({nm, "_busy_cycles"}, 64'(g_busy), 64'(e.lat));
        if (e.post) begin
          chk({nm, "_q*d+r"}, {32'b0, quotient} * {32'b0, e.dv} + {32'b0, remainder}, e.dd);
          chk({nm, "_r<d"}, 64'(remainder < e.dv), 64'd1);
          chk({nm, "_flags"}, {62'b0, div_by_zero, overflow}, 64'd0);
        end else begin
          chk({nm, "_quotient"}, 64'(quotient), 64'(e.q));
          chk({nm, "_remainder"}, 64'(remainder), 64'(e.r));
          chk({nm, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
          chk({nm, "_overflow"}, 64'(overflow), 64'(e.ovf));
        end
      end
    end
    $display("op %s: dd=%h dv=%h q=%h r=%h dbz=%0b ovf=%0b cyc=%0d",
             nm, e.dd, e.dv, quotient, remainder, div_by_zero, overflow, g_cyc);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_quotient"}, 64'(quotient), 64'd0);
    chk({nm, "_remainder"}, 64'(remainder), 64'd0);
    chk({nm, "_div_by_zero"}, 64'(div_by_zero), 64'd0);
    chk({nm, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    exp_t   e;
    dword_t tp1_dd;
    dword_t tp2_dd;
    word_t  rdv;

    tp1_dd = 64'(32'h13404874) * 64'(32'h11E2F516) + 64'd5;
    tp2_dd = 64'(32'h00004874) * 64'(32'h0000F516);

    vec[0] = mk(tp1_dd, 32'h11E2F516, 32'h13404874, 32'd5, 1'b0, 1'b0, 34);
    vec[1] = mk(64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 34);
    vec[2] = mk(64'h00000001_00000000, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 2);
    vec[3] = mk(64'h12345678_9ABCDEF0, 32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 1'b1, 1'b0, 2);
    vec[4] = mk(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);
    vec[5] = mk(64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 34);
    vec[6] = mk(64'h00000004_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0, 1'b0, 34);
    vec[7] = mk(64'h80000000_00000000, 32'h80000001, 32'hFFFFFFFE, 32'd2, 1'b0, 1'b0, 34);
    vec[8] = mk(64'h00000007_00000000, 32'd7, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 2);
    vec[9] = mk(64'h00000005_00000003, 32'd0, 32'hFFFFFFFF, 32'd3, 1'b1, 1'b0, 2);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vec[i]);
      wait_done($sformatf("vec%0d", i));
    end

    // Back-to-back: the second start is raised in the done cycle of the first.
    issue(vec[0]);
    wait_done("b2b_first");
    chk("b2b_done_high_at_issue", 64'(done), 64'd1);
    issue(mk(tp2_dd, 32'h0000F516, 32'h00004874, 32'd0, 1'b0, 1'b0, 34));
    wait_done("b2b_second");

    // Start pulse and operand changes mid-run must be ignored and not queued.
    issue(vec[4]);
    repeat (5) tick();
    @(negedge clk);
    start    = 1'b1;
    dividend = 64'h00000000_DEADBEEF;
    divisor  = 32'd3;
    tick();
    start = 1'b0;
    wait_done("ignored_start");
    tick();
    chk("done_single_pulse", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("start_not_queued", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of RUN aborts without a done pulse.
    issue(vec[6]);
    while (g_cyc < 11) tick();
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    void'(sb.pop_back());
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_done_in_reset", 64'(done), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_done_after_abort", 64'(done), 64'd0);
      chk("idle_after_abort", 64'(busy), 64'd0);
    end
    issue(vec[7]);
    wait_done("after_reset");

    for (int i = 0; i < 1000; i++) begin
      rdv = $urandom;
      if (rdv == '0) rdv = 32'd1;
      e.dd   = {32'($urandom_range(rdv - 32'd1, 0)), 32'($urandom)};
      e.dv   = rdv;
      e.q    = '0;
      e.r    = '0;
      e.dbz  = 1'b0;
      e.ovf  = 1'b0;
      e.lat  = 34;
      e.post = 1'b1;
      issue(e);
      wait_done($sformatf("rnd%0d", i));
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
